// File: rtl/stream_capture_fifo_pkg.sv
// Shared capture package: FSM state encoding and pointer sizing helpers
// used by the capture FIFO and the filter-chain blocks.
package stream_capture_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_RUN  = 2'd2
    } cap_state_e;

    // Pointer carries one extra MSB so full and empty stay distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/stream_capture_fifo_if.sv
// Sample stream in, reader pop/return and status out of the capture FIFO.
interface stream_capture_fifo_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8192
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                         data_valid;
    logic signed [DATA_WIDTH-1:0] data;
    logic                         rd_req;
    logic signed [DATA_WIDTH-1:0] rd_data;
    logic                         rd_valid;
    logic [LW-1:0]                level;
    logic                         empty;
    logic                         fifo_lleno;
    logic                         overflow;

    modport master (
        output data_valid, data, rd_req,
        input  rd_data, rd_valid, level,
        input  empty, fifo_lleno, overflow
    );

    modport slave (
        input  data_valid, data, rd_req,
        output rd_data, rd_valid, level,
        output empty, fifo_lleno, overflow
    );

endinterface

// File: rtl/stream_capture_fifo_sdpram.sv
// One write port, one registered read port; the array itself has no reset,
// only the read register does.
module simple_dual_port_ram #(
    parameter int DW = 64,
    parameter int AW = 13
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Same-address read and write returns the old word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_q <= '0;
        else if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/stream_capture_fifo.sv
// Arm/skip/run capture FIFO: drops START_SKIP samples after each arm, then
// buffers samples for a popping reader with a sticky overflow flag.
module stream_capture_fifo
    import stream_capture_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8192,
    parameter int START_SKIP = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    stream_capture_fifo_if.slave  bus
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = ptr_w(DEPTH);
    localparam int SKW = cnt_w(START_SKIP);
    localparam logic [SKW-1:0] SKIP_LAST =
        SKW'((START_SKIP > 0) ? START_SKIP - 1 : 0);

    cap_state_e     r_state;
    cap_state_e     w_next;
    logic [SKW-1:0] r_skip_cnt;
    logic [SKW-1:0] w_skip_next;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic           r_ovf;
    logic           r_rd_valid;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr_req;
    logic w_wr;
    logic w_drop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop    = !clear && bus.rd_req && !w_empty;
    assign w_wr_req = !clear && (r_state == ST_RUN) && bus.data_valid;
    // At full a same-cycle pop frees the slot being written.
    assign w_wr     = w_wr_req && (!w_full || w_pop);
    assign w_drop   = w_wr_req && w_full && !w_pop;

    always_comb begin
        w_next      = r_state;
        w_skip_next = '0;
        if (clear || !enable) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_next = (START_SKIP > 0) ? ST_SKIP : ST_RUN;
                ST_SKIP: begin
                    if (bus.data_valid && r_skip_cnt == SKIP_LAST) begin
                        w_next = ST_RUN;
                    end else begin
                        w_skip_next = r_skip_cnt + SKW'(bus.data_valid);
                    end
                end
                ST_RUN:  w_next = ST_RUN;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_skip_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ovf      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_skip_cnt <= w_skip_next;
            r_rd_valid <= w_pop;
            if (clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_wr)   r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                if (w_drop) r_ovf    <= 1'b1;
            end
        end
    end

    simple_dual_port_ram #(
        .DW (DATA_WIDTH),
        .AW (AW)
    ) u_ram (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (bus.data),
        .i_re    (w_pop),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (bus.rd_data)
    );

    assign bus.rd_valid   = r_rd_valid;
    assign bus.level      = r_wr_ptr - r_rd_ptr;
    assign bus.empty      = w_empty;
    assign bus.fifo_lleno = w_full;
    assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_stream_capture_fifo.sv
// Two capture FIFOs (deep with skip, shallow without) on one shared stimulus,
// each checked every cycle against a queue-level reference model.
module tb_stream_capture_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, clr, dv, rdq;
    logic [63:0] din;

    int n_chk  = 0;
    int n_pass = 0;

    stream_capture_fifo_if #(.DATA_WIDTH(64), .DEPTH(16)) ifa ();
    stream_capture_fifo_if #(.DATA_WIDTH(64), .DEPTH(4))  ifb ();

    assign ifa.data_valid = dv;
    assign ifa.data       = din;
    assign ifa.rd_req     = rdq;
    assign ifb.data_valid = dv;
    assign ifb.data       = din;
    assign ifb.rd_req     = rdq;

    stream_capture_fifo #(
        .DATA_WIDTH(64), .DEPTH(16), .START_SKIP(3)
    ) u_a (
        .clock(clk), .reset(rst_n), .enable(en), .clear(clr), .bus(ifa)
    );

    stream_capture_fifo #(
        .DATA_WIDTH(64), .DEPTH(4), .START_SKIP(0)
    ) u_b (
        .clock(clk), .reset(rst_n), .enable(en), .clear(clr), .bus(ifb)
    );

    always #5 clk = ~clk;

    // Reference model: circular store per instance, spec-level state rules.
    localparam int M_IDLE = 0, M_SKIP = 1, M_RUN = 2;
    int          m_depth [2] = '{16, 4};
    int          m_skip  [2] = '{3, 0};
    int          m_cnt   [2];
    int          m_head  [2];
    int          m_st    [2];
    int          m_skd   [2];
    bit          m_ov    [2];
    bit          m_rdv   [2];
    logic [63:0] m_rdd   [2];
    logic [63:0] m_mem   [2][16];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_head[k] = 0; m_st[k] = M_IDLE; m_skd[k] = 0;
            m_ov[k] = 0; m_rdv[k] = 0; m_rdd[k] = '0;
        end
    endtask

    task automatic model_step(input int k);
        bit pop, full, wr;
        if (clr) begin
            m_cnt[k] = 0; m_head[k] = 0; m_ov[k] = 0;
            m_st[k] = M_IDLE; m_skd[k] = 0; m_rdv[k] = 0;
            return;
        end
        pop  = rdq && (m_cnt[k] > 0);
        full = (m_cnt[k] == m_depth[k]);
        wr   = (m_st[k] == M_RUN) && dv;
        m_rdv[k] = pop;
        if (pop) begin
            m_rdd[k]  = m_mem[k][m_head[k]];
            m_head[k] = (m_head[k] + 1) % 16;
            m_cnt[k]--;
        end
        if (wr) begin
            if (full && !pop) m_ov[k] = 1;
            else begin
                m_mem[k][(m_head[k] + m_cnt[k]) % 16] = din;
                m_cnt[k]++;
            end
        end
        if (!en) begin
            m_st[k] = M_IDLE; m_skd[k] = 0;
        end else if (m_st[k] == M_IDLE) begin
            m_st[k] = (m_skip[k] > 0) ? M_SKIP : M_RUN; m_skd[k] = 0;
        end else if (m_st[k] == M_SKIP && dv) begin
            m_skd[k]++;
            if (m_skd[k] == m_skip[k]) m_st[k] = M_RUN;
        end
    endtask

    task automatic compare();
        chk("A.level", 64'(ifa.level),      64'(m_cnt[0]));
        chk("A.empty", 64'(ifa.empty),      64'(m_cnt[0] == 0));
        chk("A.full",  64'(ifa.fifo_lleno), 64'(m_cnt[0] == m_depth[0]));
        chk("A.ovf",   64'(ifa.overflow),   64'(m_ov[0]));
        chk("A.rdv",   64'(ifa.rd_valid),   64'(m_rdv[0]));
        chk("A.rdd",   64'(ifa.rd_data),    m_rdd[0]);
        chk("B.level", 64'(ifb.level),      64'(m_cnt[1]));
        chk("B.empty", 64'(ifb.empty),      64'(m_cnt[1] == 0));
        chk("B.full",  64'(ifb.fifo_lleno), 64'(m_cnt[1] == m_depth[1]));
        chk("B.ovf",   64'(ifb.overflow),   64'(m_ov[1]));
        chk("B.rdv",   64'(ifb.rd_valid),   64'(m_rdv[1]));
        chk("B.rdd",   64'(ifb.rd_data),    m_rdd[1]);
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle_in();
        clr = 0; dv = 0; rdq = 0; din = '0;
    endtask

    // Called just after a posedge; reset lands mid-cycle.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 model_reset();
        compare();
        #2 rst_n = 1'b1;
        en = 0; idle_in();
        step();
    endtask

    task automatic do_clear();
        en = 0; idle_in(); clr = 1; step(); clr = 0;
    endtask

    task automatic arm();
        en = 1; idle_in(); step();
    endtask

    task automatic push(input logic [63:0] v);
        dv = 1; din = v; rdq = 0; step(); dv = 0;
    endtask

    task automatic pop_b(input string tag, input logic [63:0] v);
        rdq = 1; step(); rdq = 0;
        chk({tag, ".v"}, 64'(ifb.rd_valid), 64'd1);
        chk({tag, ".d"}, 64'(ifb.rd_data), v);
    endtask

    task automatic pop_a(input string tag, input logic [63:0] v);
        rdq = 1; step(); rdq = 0;
        chk({tag, ".v"}, 64'(ifa.rd_valid), 64'd1);
        chk({tag, ".d"}, 64'(ifa.rd_data), v);
    endtask

    initial begin
        rst_n = 1'b0; en = 0; idle_in();
        @(posedge clk);
        do_reset();

        // Skip three after arm, keep 4..10
        arm();
        for (int i = 1; i <= 10; i++) push(64'(i));
        chk("skip.level", 64'(ifa.level), 64'd7);
        for (int i = 4; i <= 10; i++) pop_a("skip.pop", 64'(i));
        do_clear();

        // Overflow on the shallow instance
        arm();
        for (int i = 10; i <= 15; i++) push(64'(i));
        chk("ovf.full", 64'(ifb.fifo_lleno), 64'd1);
        chk("ovf.flag", 64'(ifb.overflow), 64'd1);
        for (int i = 10; i <= 13; i++) pop_b("ovf.pop", 64'(i));
        do_clear();

        // Write and pop together at full
        arm();
        for (int i = 20; i <= 23; i++) push(64'(i));
        dv = 1; din = 64'd99; rdq = 1; step(); idle_in();
        chk("full.rw.level", 64'(ifb.level), 64'd4);
        chk("full.rw.ovf", 64'(ifb.overflow), 64'd0);
        chk("full.rw.d", 64'(ifb.rd_data), 64'd20);
        for (int i = 21; i <= 23; i++) pop_b("full.pop", 64'(i));
        pop_b("full.last", 64'd99);
        do_clear();

        // Pop on empty; write+pop on empty does not fall through
        rdq = 1; step(); rdq = 0;
        chk("empty.rdv", 64'(ifb.rd_valid), 64'd0);
        chk("empty.level", 64'(ifb.level), 64'd0);
        arm();
        dv = 1; din = 64'd55; rdq = 1; step(); idle_in();
        chk("nofall.rdv", 64'(ifb.rd_valid), 64'd0);
        chk("nofall.level", 64'(ifb.level), 64'd1);
        pop_b("nofall.pop", 64'd55);
        do_clear();

        // Enable dropped for 5 cycles, then re-arm re-skips
        arm();
        for (int i = 1; i <= 4; i++) push(64'(i));
        en = 0; step();
        for (int i = 5; i <= 8; i++) push(64'(i));
        arm();
        for (int i = 20; i <= 27; i++) push(64'(i));
        chk("rearm.level", 64'(ifa.level), 64'd6);
        pop_a("rearm.first", 64'd4);
        pop_a("rearm.second", 64'd23);
        do_clear();

        // Clear with pop requested, then reset with pop in flight
        arm();
        for (int i = 1; i <= 6; i++) push(64'(i));
        chk("clr.pre.level", 64'(ifa.level), 64'd3);
        clr = 1; rdq = 1; step(); idle_in();
        chk("clr.level", 64'(ifa.level), 64'd0);
        chk("clr.empty", 64'(ifa.empty), 64'd1);
        chk("clr.rdv", 64'(ifa.rd_valid), 64'd0);
        chk("clr.ovf", 64'(ifa.overflow), 64'd0);
        arm();
        for (int i = 1; i <= 6; i++) push(64'(i));
        rdq = 1; step(); rdq = 0;
        chk("rst.inflight", 64'(ifa.rd_valid), 64'd1);
        do_reset();
        chk("rst.level", 64'(ifa.level), 64'd0);
        chk("rst.empty", 64'(ifa.empty), 64'd1);
        chk("rst.rdv", 64'(ifa.rd_valid), 64'd0);

        // Randomized traffic across read-pressure phases
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 300; c++) begin
                en  = ($urandom_range(0, 24) != 0);
                clr = ($urandom_range(0, 79) == 0);
                dv  = ($urandom_range(0, 3) != 0);
                din = {$urandom, $urandom};
                case (ph)
                    0:       rdq = ($urandom_range(0, 3) == 0);
                    1:       rdq = ($urandom_range(0, 1) == 0);
                    default: rdq = ($urandom_range(0, 3) != 0);
                endcase
                if ($urandom_range(0, 249) == 0) do_reset();
                else step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_capture_fifo.md
STREAM_CAPTURE_FIFO -- requirements
Module: stream_capture_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: sample width, signed, matching the filter output stream.
REQ-002 SHALL have parameter DEPTH, default 8192: buffer capacity in samples; must be a power of two, at least 4.
REQ-003 SHALL have parameter START_SKIP, default 0: number of valid samples discarded after each arm.
REQ-004 SHALL have port clock  in  1: single clock for all logic.
REQ-005 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1: arms capture while high.
REQ-007 SHALL have port clear  in  1: synchronous flush of pointers, state and flags.
REQ-008 SHALL have port data_valid  in  1: input sample strobe.
REQ-009 SHALL have port data  in  DATA_WIDTH: input sample, signed.
REQ-010 SHALL have port rd_req  in  1: reader pop request.
REQ-011 SHALL have port rd_data  out  DATA_WIDTH: popped sample.
REQ-012 SHALL have port rd_valid  out  1: rd_data qualifier, one-cycle pulse.
REQ-013 SHALL have port level  out  $clog2(DEPTH)+1: stored sample count.
REQ-014 SHALL have port empty  out  1: asserted when level == 0.
REQ-015 SHALL have port fifo_lleno  out  1: asserted when level == DEPTH.
REQ-016 SHALL have port overflow  out  1: sticky flag, set when a sample is dropped.

Function
REQ-017 SHALL implement an FSM with states IDLE, SKIP and RUN.
- From IDLE with enable=1: go to SKIP when START_SKIP>0, otherwise to RUN.
- From SKIP: go to RUN once START_SKIP valid samples have been discarded.
- From any state with enable=0: go to IDLE on the next edge; a later re-arm restarts the skip count.
REQ-018 SHALL write data into the buffer only in RUN, on a cycle with data_valid=1, with a write latency of 0; the sample is visible in level on the next cycle.
REQ-019 SHALL discard the sample in RUN when fifo_lleno=1 and no pop occurs that cycle, and set overflow.
REQ-020 SHALL, when fifo_lleno=1 and a write and a pop occur in the same cycle, accept both; level stays DEPTH and overflow is unchanged.
REQ-021 SHALL accept a pop when rd_req=1 and empty=0, in any state; a pop on empty SHALL be ignored, with no rd_valid and no flag change.
REQ-022 SHALL present rd_data with rd_valid=1 exactly one cycle after an accepted pop (registered RAM read); rd_data holds its value otherwise.
REQ-023 SHALL, on a simultaneous write and pop with empty=0, leave level unchanged and return the oldest sample.
REQ-024 SHALL, on a write into an empty buffer, not allow that sample to be popped in the same cycle (no fall-through).
REQ-025 SHALL wrap the read and write pointers modulo DEPTH; the full/empty distinction SHALL use an extra pointer MSB.
REQ-026 SHALL give clear priority over all other inputs: pointers 0, level 0, overflow 0, state IDLE, and the pending rd_valid suppressed.
REQ-027 SHALL store and return data bit-exact, with no sign or width conversion.

Reset
REQ-028 SHALL, when reset=0, asynchronously force: state IDLE, both pointers 0, skip counter 0, rd_valid 0, rd_data 0, overflow 0, level 0, empty 1, fifo_lleno 0.
REQ-029 SHALL not depend on RAM contents after reset; stale words are never output because empty=1.
REQ-030 SHALL, on reset asserted mid-operation, discard all buffered samples and suppress any pending rd_valid.

Structure
REQ-031 SHALL place the FSM state encoding and the pointer-width helper constant in the shared capture package, reused by the filter-chain blocks.
REQ-032 SHALL instantiate a single sub-module, simple_dual_port_ram: one write port, one registered read port, no reset on its storage array.
REQ-033 SHALL keep the FSM, pointers, level and flags in the top-level module.

Verification
REQ-034 SHALL verify that with START_SKIP=3, enable=1 and samples 1..10 streamed, pops return 4..10 with level reaching 7.
REQ-035 SHALL verify that with DEPTH=4, six samples 10..15 and no pops, fifo_lleno=1, overflow=1, and pops return 10..13.
REQ-036 SHALL verify that at full with a simultaneous write of 99 and a pop, level stays 4 and 99 is eventually returned last.
REQ-037 SHALL verify that rd_req on empty gives rd_valid=0 and level=0, and that a write plus pop on empty in the same cycle yields rd_valid only on a later pop.
REQ-038 SHALL verify that enable dropped mid-stream for 5 cycles drops the samples sent meanwhile, and that re-arming re-skips START_SKIP samples.
REQ-039 SHALL verify that reset or clear asserted with 3 samples stored and a pop in flight gives level=0, empty=1, rd_valid=0 next cycle, and overflow=0.
